mem_port: RTL and testbench

MEM_PORT -- requirements
Module: mem_port

---
 rtl/mem_port_if.sv | 51 +++++
 rtl/mem_port.sv | 185 ++++++++++++++++++
 tb/tb_mem_port.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_if.sv
// rtl/mem_port_if.sv - request-side and word-bus-side interface bundles for mem_port
//
// mem_req_if : controller <-> mem_port load/store request channel
//   master : controller (drives req/req_*; observes busy, done, err, rdata)
//   slave  : mem_port
// mem_bus_if : mem_port <-> external 32-bit word bus
//   master : mem_port (drives bus_valid/bus_we/bus_addr/bus_be/bus_wdata)
//   slave  : memory (drives bus_ready/bus_rdata)

interface mem_req_if;
    logic        req;
    logic        req_we;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] rdata;

    modport master (
        output req, req_we, req_addr, req_size, req_signed, req_wdata,
        input  busy, done, err, rdata
    );

    modport slave (
        input  req, req_we, req_addr, req_size, req_signed, req_wdata,
        output busy, done, err, rdata
    );
endinterface

interface mem_bus_if;
    logic        bus_valid;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ready;
    logic [31:0] bus_rdata;

    modport master (
        output bus_valid, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_ready, bus_rdata
    );

    modport slave (
        input  bus_valid, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_ready, bus_rdata
    );
endinterface

// File: rtl/mem_port.sv
// rtl/mem_port.sv - byte/half/word load-store port onto a 32-bit word bus with timeout
//
// Ports:
//   clk    : single clock, rising edge
//   reset  : asynchronous active-high reset
//   rq     : mem_req_if.slave  - one-cycle req strobe with we/addr/size/signed/wdata,
//            busy/done/err status and extended load result rdata
//   bus    : mem_bus_if.master - valid/ready word bus, little-endian byte enables
// Parameter:
//   TIMEOUT : maximum ISSUE cycles without bus_ready before abort (1..255)

module mem_port #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic      clk,
    input  logic      reset,
    mem_req_if.slave  rq,
    mem_bus_if.master bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    // The counter value seen during the final permitted ISSUE cycle.
    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

    state_t      state;
    state_t      state_nx;
    logic [7:0]  wait_cnt;

    logic        we_r;
    logic        signed_r;
    logic [1:0]  size_r;
    logic [1:0]  lane_r;
    logic [31:0] bus_addr_r;
    logic [3:0]  bus_be_r;
    logic [31:0] bus_wdata_r;
    logic        done_r;
    logic        err_r;
    logic [31:0] rdata_r;

    logic        req_illegal;
    logic        accept;
    logic        reject;
    logic        xfer;
    logic        expire;
    logic [3:0]  be_in;
    logic [31:0] wdata_in;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_val;

    // Request decode, lane mapping and store-data replication
    always_comb begin
        req_illegal = 1'b0;
        be_in       = 4'b1111;
        wdata_in    = rq.req_wdata;
        case (rq.req_size)
            2'b00: begin
                be_in    = 4'b0001 << rq.req_addr[1:0];
                wdata_in = {4{rq.req_wdata[7:0]}};
            end
            2'b01: begin
                req_illegal = rq.req_addr[0];
                be_in       = 4'b0011 << {rq.req_addr[1], 1'b0};
                wdata_in    = {2{rq.req_wdata[15:0]}};
            end
            2'b10: begin
                req_illegal = (rq.req_addr[1:0] != 2'b00);
            end
            default: begin
                req_illegal = 1'b1;
            end
        endcase
    end

    // Load lane select and extension from the raw bus word
    always_comb begin
        byte_sel = bus.bus_rdata[7:0];
        case (lane_r)
            2'd0:    byte_sel = bus.bus_rdata[7:0];
            2'd1:    byte_sel = bus.bus_rdata[15:8];
            2'd2:    byte_sel = bus.bus_rdata[23:16];
            default: byte_sel = bus.bus_rdata[31:24];
        endcase
        half_sel = lane_r[1] ? bus.bus_rdata[31:16] : bus.bus_rdata[15:0];
        case (size_r)
            2'b00:   load_val = {{24{signed_r & byte_sel[7]}}, byte_sel};
            2'b01:   load_val = {{16{signed_r & half_sel[15]}}, half_sel};
            default: load_val = bus.bus_rdata;
        endcase
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        reject   = 1'b0;
        xfer     = 1'b0;
        expire   = 1'b0;
        case (state)
            IDLE: begin
                if (rq.req) begin
                    if (req_illegal) begin
                        reject = 1'b1;
                    end else begin
                        accept   = 1'b1;
                        state_nx = ISSUE;
                    end
                end
            end
            ISSUE: begin
                // A ready in the last permitted cycle still completes the transfer.
                if (bus.bus_ready) begin
                    xfer     = 1'b1;
                    state_nx = RESP;
                end else if (wait_cnt == LAST_WAIT) begin
                    expire   = 1'b1;
                    state_nx = RESP;
                end
            end
            RESP: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            wait_cnt    <= 8'd0;
            we_r        <= 1'b0;
            signed_r    <= 1'b0;
            size_r      <= 2'b00;
            lane_r      <= 2'b00;
            bus_addr_r  <= 32'd0;
            bus_be_r    <= 4'd0;
            bus_wdata_r <= 32'd0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
            rdata_r     <= 32'd0;
        end else begin
            state  <= state_nx;
            done_r <= xfer;
            err_r  <= reject | expire;

            if (accept) begin
                wait_cnt    <= 8'd0;
                we_r        <= rq.req_we;
                signed_r    <= rq.req_signed;
                size_r      <= rq.req_size;
                lane_r      <= rq.req_addr[1:0];
                bus_addr_r  <= {rq.req_addr[31:2], 2'b00};
                bus_be_r    <= be_in;
                bus_wdata_r <= wdata_in;
            end else if (state == ISSUE) begin
                wait_cnt <= wait_cnt + 8'd1;
            end

            if (xfer && !we_r) begin
                rdata_r <= load_val;
            end
        end
    end

    // Bus strobes derive from the state register so reset clears them at once;
    // address/enables/data are held registers, stable throughout ISSUE.
    assign bus.bus_valid = (state == ISSUE);
    assign bus.bus_we    = (state == ISSUE) & we_r;
    assign bus.bus_addr  = bus_addr_r;
    assign bus.bus_be    = bus_be_r;
    assign bus.bus_wdata = bus_wdata_r;

    assign rq.busy  = (state != IDLE);
    assign rq.done  = done_r;
    assign rq.err   = err_r;
    assign rq.rdata = rdata_r;

endmodule

// File: tb/tb_mem_port.sv
// tb/tb_mem_port.sv - self-checking bench for mem_port

module tb_mem_port;

    localparam int TO = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_req_if rq();
    mem_bus_if bs();

    mem_port #(.TIMEOUT(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .rq    (rq.slave),
        .bus   (bs.master)
    );

    int total = 0;
    int bad   = 0;
    logic [31:0] model_rdata;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [1:0]  size;
        logic        sg;
        logic [31:0] wdata;
        int          lat;
        logic [31:0] brd;
        logic [3:0]  exp_be;
        logic [31:0] exp_bwd;
        logic        exp_err;
        logic [31:0] exp_rdata;
        logic        chk_bus;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic logic m_illegal(input logic [1:0] sz, input logic [31:0] a);
        int lo = int'(a[1:0]);
        if (sz == 2'd3) return 1'b1;
        if (sz == 2'd1) return (lo % 2) != 0;
        if (sz == 2'd2) return lo != 0;
        return 1'b0;
    endfunction

    function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [31:0] a);
        int lo = int'(a[1:0]);
        if (sz == 2'd0) return 4'(1 << lo);
        if (sz == 2'd1) return 4'(3 << (lo / 2 * 2));
        return 4'hF;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] wd);
        if (sz == 2'd0) return (wd & 32'hFF) * 32'h01010101;
        if (sz == 2'd1) return (wd & 32'hFFFF) * 32'h00010001;
        return wd;
    endfunction

    function automatic logic [31:0] m_load(input logic [1:0] sz, input logic [31:0] a,
                                           input logic sg, input logic [31:0] brd);
        logic [31:0] v;
        logic [31:0] x;
        v = brd >> (8 * int'(a[1:0]));
        if (sz == 2'd0) begin
            x = v & 32'hFF;
            if (sg && x >= 32'd128) x = x - 32'd256;
        end else if (sz == 2'd1) begin
            x = v & 32'hFFFF;
            if (sg && x >= 32'd32768) x = x - 32'd65536;
        end else begin
            x = brd;
        end
        return x;
    endfunction

    // Drives one request and follows it through to IDLE, checking every cycle.
    task automatic run_txn(input logic we, input logic [31:0] a, input logic [1:0] sz,
                           input logic sg, input logic [31:0] wd, input int lat,
                           input logic [31:0] brd,
                           output logic [3:0] obs_be, output logic [31:0] obs_wd,
                           output logic obs_done, output logic obs_err);
        logic ill;
        logic tmo;
        ill = m_illegal(sz, a);
        tmo = !ill && (lat >= TO);
        obs_be = 4'd0;
        obs_wd = 32'd0;

        @(negedge clk);
        rq.req        = 1'b1;
        rq.req_we     = we;
        rq.req_addr   = a;
        rq.req_size   = sz;
        rq.req_signed = sg;
        rq.req_wdata  = wd;
        bs.bus_ready  = (lat == 0);
        bs.bus_rdata  = brd;

        @(negedge clk);
        rq.req        = 1'b0;
        rq.req_we     = 1'($urandom);
        rq.req_addr   = $urandom;
        rq.req_size   = 2'($urandom);
        rq.req_signed = 1'($urandom);
        rq.req_wdata  = $urandom;

        if (ill) begin
            obs_done = rq.done;
            obs_err  = rq.err;
            chk("ill_err", rq.err, 1'b1);
            chk("ill_done", rq.done, 1'b0);
            chk("ill_busy", rq.busy, 1'b0);
            chk("ill_valid", bs.bus_valid, 1'b0);
            bs.bus_ready = 1'b0;
            @(negedge clk);
            chk("ill_err_clear", rq.err, 1'b0);
            chk("ill_valid2", bs.bus_valid, 1'b0);
            chk("ill_busy2", rq.busy, 1'b0);
            return;
        end

        for (int k = 0; k < TO; k++) begin
            if (k == 0) begin
                obs_be = bs.bus_be;
                obs_wd = bs.bus_wdata;
            end
            chk("iss_valid", bs.bus_valid, 1'b1);
            chk("iss_busy", rq.busy, 1'b1);
            chk("iss_we", bs.bus_we, we);
            chk("iss_addr", bs.bus_addr, a & 32'hFFFF_FFFC);
            chk("iss_be", bs.bus_be, m_be(sz, a));
            if (we) chk("iss_wdata", bs.bus_wdata, m_wdata(sz, wd));
            chk("iss_done", rq.done, 1'b0);
            chk("iss_err", rq.err, 1'b0);
            bs.bus_ready = (k == lat);
            @(negedge clk);
            if (k == lat) break;
        end

        obs_done = rq.done;
        obs_err  = rq.err;
        chk("resp_done", rq.done, !tmo);
        chk("resp_err", rq.err, tmo);
        chk("resp_valid", bs.bus_valid, 1'b0);
        if (!tmo && !we) model_rdata = m_load(sz, a, sg, brd);
        chk("resp_rdata", rq.rdata, model_rdata);
        bs.bus_ready = 1'b0;
        // A legal request during RESP must be dropped, not queued.
        rq.req       = 1'b1;
        rq.req_we    = 1'b0;
        rq.req_addr  = 32'h0;
        rq.req_size  = 2'd2;

        @(negedge clk);
        rq.req = 1'b0;
        chk("idle_busy", rq.busy, 1'b0);
        chk("idle_valid", bs.bus_valid, 1'b0);
        chk("idle_done", rq.done, 1'b0);
        chk("idle_err", rq.err, 1'b0);
        chk("idle_rdata", rq.rdata, model_rdata);
    endtask

    vec_t vecs[12];

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  o_be;
        logic [31:0] o_wd;
        logic        o_done;
        logic        o_err;

        vecs[0]  = '{1'b0, 32'h10, 2'd2, 1'b0, 32'h0,        0, 32'hDEADBEEF, 4'hF, 32'h0,        1'b0, 32'hDEADBEEF, 1'b1};
        vecs[1]  = '{1'b0, 32'h13, 2'd0, 1'b1, 32'h0,        0, 32'h80112233, 4'h8, 32'h0,        1'b0, 32'hFFFFFF80, 1'b1};
        vecs[2]  = '{1'b0, 32'h13, 2'd0, 1'b0, 32'h0,        0, 32'h80112233, 4'h8, 32'h0,        1'b0, 32'h00000080, 1'b1};
        vecs[3]  = '{1'b1, 32'h22, 2'd1, 1'b0, 32'h0000ABCD, 3, 32'h0,        4'hC, 32'hABCDABCD, 1'b0, 32'h00000080, 1'b1};
        vecs[4]  = '{1'b0, 32'h06, 2'd2, 1'b0, 32'h0,        0, 32'h0,        4'h0, 32'h0,        1'b1, 32'h00000080, 1'b0};
        vecs[5]  = '{1'b0, 32'h40, 2'd3, 1'b0, 32'h0,        0, 32'h0,        4'h0, 32'h0,        1'b1, 32'h00000080, 1'b0};
        vecs[6]  = '{1'b0, 32'h44, 2'd2, 1'b0, 32'h0,        9, 32'h12345678, 4'hF, 32'h0,        1'b1, 32'h00000080, 1'b1};
        vecs[7]  = '{1'b0, 32'h02, 2'd1, 1'b1, 32'h0,        1, 32'h80010000, 4'hC, 32'h0,        1'b0, 32'hFFFF8001, 1'b1};
        vecs[8]  = '{1'b0, 32'h00, 2'd1, 1'b0, 32'h0,        2, 32'h1234F00D, 4'h3, 32'h0,        1'b0, 32'h0000F00D, 1'b1};
        vecs[9]  = '{1'b1, 32'h01, 2'd0, 1'b0, 32'h1234565A, 0, 32'h0,        4'h2, 32'h5A5A5A5A, 1'b0, 32'h0000F00D, 1'b1};
        vecs[10] = '{1'b0, 32'h05, 2'd1, 1'b0, 32'h0,        0, 32'h0,        4'h0, 32'h0,        1'b1, 32'h0000F00D, 1'b0};
        vecs[11] = '{1'b0, 32'h08, 2'd2, 1'b0, 32'h0,     TO-1, 32'h0BADCAFE, 4'hF, 32'h0,        1'b0, 32'h0BADCAFE, 1'b1};

        reset         = 1'b1;
        rq.req        = 1'b0;
        rq.req_we     = 1'b0;
        rq.req_addr   = 32'h0;
        rq.req_size   = 2'd0;
        rq.req_signed = 1'b0;
        rq.req_wdata  = 32'h0;
        bs.bus_ready  = 1'b0;
        bs.bus_rdata  = 32'h0;
        model_rdata   = 32'h0;
        #12;
        chk("rst_busy", rq.busy, 1'b0);
        chk("rst_done", rq.done, 1'b0);
        chk("rst_err", rq.err, 1'b0);
        chk("rst_rdata", rq.rdata, 32'h0);
        chk("rst_valid", bs.bus_valid, 1'b0);
        chk("rst_we", bs.bus_we, 1'b0);
        chk("rst_addr", bs.bus_addr, 32'h0);
        chk("rst_be", bs.bus_be, 4'h0);
        chk("rst_wdata", bs.bus_wdata, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 12; i++) begin
            run_txn(vecs[i].we, vecs[i].addr, vecs[i].size, vecs[i].sg, vecs[i].wdata,
                    vecs[i].lat, vecs[i].brd, o_be, o_wd, o_done, o_err);
            chk($sformatf("vec%0d_err", i), o_err, vecs[i].exp_err);
            chk($sformatf("vec%0d_done", i), o_done, !vecs[i].exp_err);
            chk($sformatf("vec%0d_rdata", i), rq.rdata, vecs[i].exp_rdata);
            if (vecs[i].chk_bus) begin
                chk($sformatf("vec%0d_be", i), o_be, vecs[i].exp_be);
                if (vecs[i].we) chk($sformatf("vec%0d_bwd", i), o_wd, vecs[i].exp_bwd);
            end
        end

        // Reset in the middle of ISSUE: outputs clear without waiting for a clock edge.
        @(negedge clk);
        rq.req       = 1'b1;
        rq.req_we    = 1'b1;
        rq.req_addr  = 32'h30;
        rq.req_size  = 2'd2;
        rq.req_wdata = 32'h11223344;
        bs.bus_ready = 1'b0;
        @(negedge clk);
        rq.req = 1'b0;
        chk("mid_valid_pre", bs.bus_valid, 1'b1);
        @(negedge clk);
        #2;
        reset = 1'b1;
        model_rdata = 32'h0;
        #1;
        chk("mid_busy", rq.busy, 1'b0);
        chk("mid_done", rq.done, 1'b0);
        chk("mid_err", rq.err, 1'b0);
        chk("mid_rdata", rq.rdata, 32'h0);
        chk("mid_valid", bs.bus_valid, 1'b0);
        chk("mid_we", bs.bus_we, 1'b0);
        chk("mid_addr", bs.bus_addr, 32'h0);
        chk("mid_be", bs.bus_be, 4'h0);
        chk("mid_wdata", bs.bus_wdata, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_done", rq.done, 1'b0);
            chk("post_rst_err", rq.err, 1'b0);
            chk("post_rst_busy", rq.busy, 1'b0);
        end
        run_txn(1'b0, 32'h30, 2'd2, 1'b0, 32'h0, 1, 32'hCAFEF00D, o_be, o_wd, o_done, o_err);
        chk("post_rst_lw_done", o_done, 1'b1);
        chk("post_rst_lw_rdata", rq.rdata, 32'hCAFEF00D);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 80; i++) begin
            logic [31:0] ra;
            ra = $urandom;
            run_txn(1'($urandom), ra, 2'($urandom), 1'($urandom), $urandom,
                    int'($urandom_range(0, TO + 1)), $urandom, o_be, o_wd, o_done, o_err);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
